// File: rtl/clock_works.sv
// Board clock/reset generator: divides the board clock into the SoC clock and produces a
// stretched, synchronous active-low reset. Optional reset debouncer: CLOCKWORKS_DEBOUNCE_EN.
module clock_works #(
    parameter int unsigned SLOW          = 0,
    parameter int unsigned RESET_HOLD    = 15,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    // RESET_HOLD=0 still needs a one-bit counter so the vector stays legal.
    localparam int unsigned RW   = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [RW-1:0] HOLD = RW'(RESET_HOLD);
    localparam logic [RW-1:0] RONE = RW'(1);

    // No reset input exists upstream of this block, so state relies on FPGA power-up values.
    logic          rst_in;
    logic          s1       = 1'b0;
    logic          s2       = 1'b0;
    logic [RW-1:0] rcnt     = {RW{1'b0}};
    logic          resetn_q = 1'b0;

    if (DEBOUNCE_BITS < 1) begin : g_bad_debounce_bits
        $error("clock_works: DEBOUNCE_BITS must be at least 1");
    end

    if (SLOW > 0) begin : g_div
        localparam logic [SLOW:0] DONE = (SLOW + 1)'(1);
        logic [SLOW:0] div = {(SLOW + 1){1'b0}};

        // Free-running divider; its top bit is the system clock.
        always_ff @(posedge CLK) begin
            div <= div + DONE;
        end

        assign clk = div[SLOW];
    end else begin : g_nodiv
        assign clk = CLK;
    end

`ifdef CLOCKWORKS_DEBOUNCE_EN
    localparam logic [DEBOUNCE_BITS-1:0] DBONE = DEBOUNCE_BITS'(1);
    logic                     d1   = 1'b0;
    logic                     d2   = 1'b0;
    logic                     db   = 1'b0;
    logic [DEBOUNCE_BITS-1:0] dcnt = {DEBOUNCE_BITS{1'b0}};

    // Synchronise the button into CLK; flip the level only after a long stable run.
    always_ff @(posedge CLK) begin
        d1 <= RESET;
        d2 <= d1;
        if (d2 == db) begin
            dcnt <= {DEBOUNCE_BITS{1'b0}};
        end else if (&dcnt) begin
            db   <= ~db;
            dcnt <= {DEBOUNCE_BITS{1'b0}};
        end else begin
            dcnt <= dcnt + DBONE;
        end
    end

    assign rst_in = db;
`else
    assign rst_in = RESET;
`endif

    // Two-flop synchroniser into the system clock domain.
    always_ff @(posedge clk) begin
        s1 <= rst_in;
        s2 <= s1;
    end

    // Hold resetn low for RESET_HOLD edges after the synchronised button goes low.
    always_ff @(posedge clk) begin
        if (s2) begin
            rcnt     <= {RW{1'b0}};
            resetn_q <= 1'b0;
        end else if (rcnt < HOLD) begin
            rcnt     <= rcnt + RONE;
            resetn_q <= 1'b0;
        end else begin
            rcnt     <= rcnt;
            resetn_q <= 1'b1;
        end
    end

    assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_works.sv
// Directed bench for clock_works: three instances (SLOW=2/1/0) checked against hand-derived
// clock and reset timing; debouncer checks replace the exact reset timing when CLOCKWORKS_DEBOUNCE_EN is set.
module tb_clock_works;

    logic CLK    = 1'b0;
    logic rst_s2 = 1'b0;
    logic rst_s1 = 1'b0;
    logic rst_s0 = 1'b0;
    logic clk_s2, resetn_s2;
    logic clk_s1, resetn_s1;
    logic clk_s0, resetn_s0;

    int n           = 0;
    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    clock_works #(.SLOW(2), .RESET_HOLD(15), .DEBOUNCE_BITS(16)) u_s2 (
        .CLK(CLK), .RESET(rst_s2), .clk(clk_s2), .resetn(resetn_s2));
    clock_works #(.SLOW(1), .RESET_HOLD(3), .DEBOUNCE_BITS(16)) u_s1 (
        .CLK(CLK), .RESET(rst_s1), .clk(clk_s1), .resetn(resetn_s1));
    clock_works #(.SLOW(0), .RESET_HOLD(2), .DEBOUNCE_BITS(4)) u_s0 (
        .CLK(CLK), .RESET(rst_s0), .clk(clk_s0), .resetn(resetn_s0));

    task automatic check(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at CLK edge %0d", tag, observed, expected, n);
        end
    endtask

    // One CLK posedge, sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
        n++;
    endtask

    // u_s1 clk rises on CLK edges 2, 6, 10, ...
    task automatic s1_edge();
        do tick(); while (n % 4 != 2);
    endtask

    initial begin
        // Power-up: divider waveforms and stretcher release for every instance.
        for (int i = 0; i < 40; i++) begin
            tick();
            check("clk_div8", clk_s2, (n % 8) >= 4);
            check("clk_div4", clk_s1, (n % 4) >= 2);
            check("clk_pass_hi", clk_s0, CLK);
            check("s0_powerup", resetn_s0, n >= 3);
            check("s2_powerup_hold", resetn_s2, 1'b0);
            if (n % 4 == 2) begin
                check("s1_powerup", resetn_s1, ((n + 2) / 4) >= 4);
            end
            #5;
            check("clk_pass_lo", clk_s0, CLK);
        end

`ifdef CLOCKWORKS_DEBOUNCE_EN
        // 10-cycle glitch is filtered out.
        rst_s0 = 1'b1;
        repeat (10) tick();
        rst_s0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("db_glitch", resetn_s0, 1'b1);
        end
        // Long press passes the debouncer.
        rst_s0 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) check("db_hold_early", resetn_s0, 1'b1);
        end
        check("db_hold", resetn_s0, 1'b0);
        rst_s0 = 1'b0;
        repeat (40) tick();
        check("db_release", resetn_s0, 1'b1);
`else
        // SLOW=0 re-reset: sampled at edge k=41, low after 43; released at m=44, high after 48.
        rst_s0 = 1'b1;
        tick();
        check("s0_rst_k", resetn_s0, 1'b1);
        tick();
        check("s0_rst_k1", resetn_s0, 1'b1);
        tick();
        check("s0_rst_k2", resetn_s0, 1'b0);
        rst_s0 = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            tick();
            check("s0_release", resetn_s0, i == 4);
        end

        // SLOW=1 button press for 5 clk periods.
        rst_s1 = 1'b1;
        s1_edge();
        check("s1_press_k", resetn_s1, 1'b1);
        s1_edge();
        check("s1_press_k1", resetn_s1, 1'b1);
        s1_edge();
        check("s1_press_k2", resetn_s1, 1'b0);
        s1_edge();
        s1_edge();
        rst_s1 = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            s1_edge();
            check("s1_release", resetn_s1, i == 5);
        end

        // Re-press while rcnt=2 restarts the stretch.
        rst_s1 = 1'b1;
        s1_edge();
        s1_edge();
        s1_edge();
        check("s1_restart_low", resetn_s1, 1'b0);
        rst_s1 = 1'b0;
        s1_edge();
        s1_edge();
        rst_s1 = 1'b1;
        s1_edge();
        rst_s1 = 1'b0;
        for (int i = 3; i <= 8; i++) begin
            s1_edge();
            check("s1_restart", resetn_s1, i == 8);
        end

        // Button held indefinitely keeps reset asserted.
        rst_s1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s1_edge();
            if (i >= 2) check("s1_held", resetn_s1, 1'b0);
        end
        rst_s1 = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            s1_edge();
            check("s1_held_release", resetn_s1, i == 5);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
